// File: rtl/mov_sum_sync_ctrl_pkg.sv
// Shared state encoding and default widths for the preamble timing-sync controller.
package mov_sum_sync_ctrl_pkg;

    localparam int unsigned DEF_DW      = 17;
    localparam int unsigned DEF_SW      = 23;
    localparam int unsigned DEF_WIN_LOG = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_FILL,
        ST_SEARCH,
        ST_DETECT
    } sync_state_t;

endpackage

// File: rtl/sync_delay_line.sv
// Circular W-sample buffer; the read at addr returns the old entry in the cycle it is overwritten.
module sync_delay_line #(
    parameter int unsigned DW = 17,
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mov_sum_sync_ctrl.sv
// Sequencing controller for the moving-window magnitude accumulator in the preamble timing-sync path.
// Define SYNC_TIMEOUT_EN to bound the SEARCH phase to TIMEOUT samples with a to_stb pulse.
module mov_sum_sync_ctrl
    import mov_sum_sync_ctrl_pkg::*;
#(
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned SW       = DEF_SW,
    parameter int unsigned WIN_LOG  = DEF_WIN_LOG,
    parameter int unsigned PLAT_LEN = 32,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 in_stb,
    input  logic [DW-1:0]        in_mag,
    input  logic signed [SW-1:0] thr,
    output logic                 acc_rst,
    output logic                 acc_ena,
    output logic [DW-1:0]        acc_a,
    output logic [DW-1:0]        acc_a_d,
    input  logic signed [SW-1:0] acc_sum,
    output logic                 busy,
    output logic                 det_stb,
    output logic [15:0]          det_idx,
    output logic                 to_stb
);

    localparam int unsigned IW = 16;
    localparam int unsigned PW = $clog2(PLAT_LEN + 1);

    sync_state_t           state;
    logic signed [SW-1:0]  thr_q;
    logic [WIN_LOG-1:0]    wr_ptr;
    logic [IW-1:0]         smp_idx;
    logic [IW-1:0]         pend_idx;
    logic                  pend;
    logic [PW-1:0]         plat_cnt;
    logic [DW-1:0]         dl_rdata;
    logic                  in_win_c;
    logic                  above_c;
    logic                  plat_done_c;
    logic                  to_hit_c;

    sync_delay_line #(
        .DW (DW),
        .AW (WIN_LOG)
    ) u_dline (
        .clk   (clk),
        .we    (acc_ena),
        .addr  (wr_ptr),
        .wdata (in_mag),
        .rdata (dl_rdata)
    );

    // FILL feeds zero as the departing sample so stale buffer contents never reach the sum.
    assign in_win_c    = (state == ST_FILL) || (state == ST_SEARCH);
    assign acc_ena     = in_win_c && in_stb;
    assign acc_a       = acc_ena ? in_mag : '0;
    assign acc_a_d     = (acc_ena && (state == ST_SEARCH)) ? dl_rdata : '0;

    assign above_c     = acc_sum >= thr_q;
    assign plat_done_c = pend && above_c && (plat_cnt == PW'(PLAT_LEN - 1));

`ifdef SYNC_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] srch_cnt;

    // Accepted SEARCH samples, saturating at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            srch_cnt <= '0;
        end else if (state == ST_CLR) begin
            srch_cnt <= '0;
        end else if (acc_ena && (state == ST_SEARCH) && (srch_cnt != TW'(TIMEOUT))) begin
            srch_cnt <= srch_cnt + TW'(1);
        end
    end

    assign to_hit_c = pend && (srch_cnt == TW'(TIMEOUT));
`else
    assign to_hit_c = 1'b0;
`endif

    // Sequencer; a SEARCH sample is judged one cycle after its strobe, once acc_sum includes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            acc_rst  <= 1'b0;
            det_stb  <= 1'b0;
            to_stb   <= 1'b0;
            det_idx  <= '0;
            thr_q    <= '0;
            wr_ptr   <= '0;
            smp_idx  <= '0;
            pend_idx <= '0;
            pend     <= 1'b0;
            plat_cnt <= '0;
        end else begin
            acc_rst <= 1'b0;
            det_stb <= 1'b0;
            to_stb  <= 1'b0;
            pend    <= acc_ena && (state == ST_SEARCH);

            if (acc_ena) begin
                wr_ptr   <= wr_ptr + WIN_LOG'(1);
                smp_idx  <= smp_idx + IW'(1);
                pend_idx <= smp_idx;
            end

            if (abort && (state != ST_IDLE)) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                pend  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state   <= ST_CLR;
                            busy    <= 1'b1;
                            acc_rst <= 1'b1;
                            thr_q   <= thr;
                            det_idx <= '0;
                        end
                    end
                    ST_CLR: begin
                        state    <= ST_FILL;
                        wr_ptr   <= '0;
                        smp_idx  <= '0;
                        plat_cnt <= '0;
                    end
                    ST_FILL: begin
                        if (acc_ena && (wr_ptr == '1)) begin
                            state <= ST_SEARCH;
                        end
                    end
                    ST_SEARCH: begin
                        if (pend) begin
                            plat_cnt <= above_c ? (plat_cnt + PW'(1)) : '0;
                            if (plat_done_c) begin
                                state   <= ST_DETECT;
                                det_stb <= 1'b1;
                                det_idx <= pend_idx;
                            end else if (to_hit_c) begin
                                state  <= ST_IDLE;
                                busy   <= 1'b0;
                                to_stb <= 1'b1;
                            end
                        end
                    end
                    ST_DETECT: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mov_sum_sync_ctrl.sv
// Bench for mov_sum_sync_ctrl: accumulator model, scenario table and event scoreboard.
module tb_mov_sum_sync_ctrl;

    localparam int DW  = 17;
    localparam int SW  = 23;
    localparam int WIN = 64;

    typedef struct {
        logic [DW-1:0]        mag;
        int                   gap;
        int                   brk;
        logic signed [SW-1:0] thr;
        int                   exp_idx;
        int                   ign_at;
        int                   ab_at;
    } row_t;

    typedef struct {
        int idx;
        int cyc;
    } ev_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 abort;
    logic                 in_stb;
    logic [DW-1:0]        in_mag;
    logic signed [SW-1:0] thr;
    logic                 acc_rst;
    logic                 acc_ena;
    logic [DW-1:0]        acc_a;
    logic [DW-1:0]        acc_a_d;
    logic signed [SW-1:0] acc_sum;
    logic                 busy;
    logic                 det_stb;
    logic [15:0]          det_idx;
    logic                 to_stb;

    int   n_chk    = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   evt_seen = 0;
    ev_t  det_q[$];
    int   to_q[$];
    logic [DW-1:0] hist [512];
    row_t rows [10];

    mov_sum_sync_ctrl #(
        .DW       (DW),
        .SW       (SW),
        .WIN_LOG  (6),
        .PLAT_LEN (32),
        .TIMEOUT  (100)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .in_stb  (in_stb),
        .in_mag  (in_mag),
        .thr     (thr),
        .acc_rst (acc_rst),
        .acc_ena (acc_ena),
        .acc_a   (acc_a),
        .acc_a_d (acc_a_d),
        .acc_sum (acc_sum),
        .busy    (busy),
        .det_stb (det_stb),
        .det_idx (det_idx),
        .to_stb  (to_stb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Accumulator model: registered running sum of newest minus departing sample.
    always @(posedge clk or negedge rst) begin
        if (!rst)         acc_sum <= '0;
        else if (acc_rst) acc_sum <= '0;
        else if (acc_ena) acc_sum <= acc_sum + $signed({6'b0, acc_a}) - $signed({6'b0, acc_a_d});
    end

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pulses are matched against expectations queued when the completing sample was driven.
    always @(negedge clk) begin
        if (rst && det_stb) begin
            evt_seen = 1;
            if (det_q.size() == 0) begin
                check("det_unexpected", 1, 0);
            end else begin
                ev_t e;
                e = det_q.pop_front();
                check("det_idx", det_idx, e.idx);
                check("det_cycle", cyc, e.cyc);
            end
        end
        if (rst && to_stb) begin
            evt_seen = 1;
            if (to_q.size() == 0) begin
                check("to_unexpected", 1, 0);
            end else begin
                int c;
                c = to_q.pop_front();
                check("to_cycle", cyc, c);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic signed [SW-1:0] th);
        start = 1; thr = th;
        tick();
        start = 0;
        in_stb = 1; in_mag = 17'd999;
        @(negedge clk);
        check("clr_cycle", {acc_rst, busy, acc_ena}, 3'b110);
        tick();
        in_stb = 0; in_mag = '0;
    endtask

    task automatic send(input int n, input logic [DW-1:0] v, input bit chk, input bit ab);
        logic [DW-1:0] exp_ad;
        hist[n] = v;
        exp_ad  = (n < WIN) ? '0 : hist[n - WIN];
        in_stb = 1; in_mag = v; abort = ab;
        @(negedge clk);
        if (chk) check("acc_if", {acc_ena, acc_a, acc_a_d}, {1'b1, v, exp_ad});
        tick();
        in_stb = 0; in_mag = '0; abort = 0;
    endtask

    task automatic run_seq(input row_t r, input int max_n, input bit to_ev);
        logic [DW-1:0] v;
        do_start(r.thr);
        evt_seen = 0;
        for (int n = 0; n < max_n && !evt_seen; n++) begin
            if (n == r.ign_at) begin
                start = 1; thr = -23'sd1;
                tick();
                start = 0; thr = r.thr;
                @(negedge clk);
                check("start_ignored", {acc_rst, busy}, 2'b01);
                tick();
            end
            v = (n == r.brk) ? '0 : r.mag;
            if (n == r.exp_idx) begin
                if (to_ev) to_q.push_back(cyc + 2);
                else       det_q.push_back('{n, cyc + 2});
            end
            send(n, v, (r.exp_idx < 0) || (n <= r.exp_idx), n == r.ab_at);
            if (n == r.ab_at) begin
                @(negedge clk);
                check("abort_idle", {busy, acc_ena}, 2'b00);
                tick();
                break;
            end
            repeat (r.gap) tick();
        end
        repeat (4) tick();
        if (r.exp_idx >= 0 || r.ab_at >= 0) begin
            check("busy_after", busy, 0);
            check("event_missing", det_q.size() + to_q.size(), 0);
        end
    endtask

    initial begin
        row_t tr;
        rows[0] = '{17'd100, 0, -1, 23'sd6400,  95,  -1, -1};
        rows[1] = '{17'd100, 0, 80, 23'sd6400,  175, -1, -1};
        rows[2] = '{17'd100, 2, -1, 23'sd6400,  95,  -1, -1};
        rows[3] = '{17'd100, 1, 80, 23'sd6400,  175, -1, -1};
        rows[4] = '{17'd200, 0, 10, 23'sd12800, 105, -1, -1};
        rows[5] = '{17'd50,  0, -1, -23'sd5,    95,  -1, -1};
        rows[6] = '{17'd100, 0, 95, 23'sd6400,  190, -1, -1};
        rows[7] = '{17'd100, 0, -1, 23'sd6400,  95,  30, -1};
        rows[8] = '{17'd100, 0, -1, 23'sd6400,  -1,  -1, 70};
        rows[9] = '{17'd100, 0, -1, 23'sd6400,  95,  -1, -1};

        rst = 0; start = 0; abort = 0; in_stb = 0; in_mag = '0; thr = '0;
        #12;
        check("reset_values", {busy, acc_rst, acc_ena, acc_a, acc_a_d, det_stb, to_stb, det_idx}, 0);
        @(negedge clk);
        rst = 1;
        tick();

        for (int i = 0; i < 10; i++) run_seq(rows[i], 400, 0);

`ifdef SYNC_TIMEOUT_EN
        tr = '{17'd100, 0, -1, 23'sd10000, 163, -1, -1};
        run_seq(tr, 300, 1);
`else
        tr = '{17'd100, 0, -1, 23'sd10000, -1, -1, -1};
        run_seq(tr, 200, 0);
        check("search_holds", busy, 1);
        abort = 1;
        tick();
        abort = 0;
        @(negedge clk);
        check("abort_after_search", busy, 0);
        tick();
`endif

        // Asynchronous reset in the middle of FILL with a live strobe.
        do_start(23'sd6400);
        for (int n = 0; n < 20; n++) send(n, 17'd100, 1, 0);
        in_stb = 1; in_mag = 17'd55;
        #2 rst = 0;
        #1;
        check("async_reset", {busy, acc_rst, acc_ena, acc_a, acc_a_d, det_stb, to_stb, det_idx}, 0);
        in_stb = 0; in_mag = '0;
        @(negedge clk);
        rst = 1;
        tick();
        run_seq(rows[0], 400, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mov_sum_sync_ctrl.md
# mov_sum_sync_ctrl

Sequencing controller for the moving-window magnitude accumulator in the OFDM 802.16 receiver's timing-synchronisation path. The controller owns the W-sample delay line and feeds the accumulator's `a` (newest sample) and `a_d` (sample W ago) inputs, gating its enable. It evaluates the running window sum against a programmable threshold and declares preamble detection once the sum has stayed on a plateau long enough.

## Interface
- `DW`, 17: sample magnitude width.
- `SW`, 23: window-sum width; must match the accumulator output.
- `WIN_LOG`, 6: window length W = 2^WIN_LOG = 64 (the short-preamble period).
- `PLAT_LEN`, 32: consecutive above-threshold samples required for detection (1..W).
- `TIMEOUT`, 4096: maximum SEARCH samples; used only when the timeout feature is compiled in.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse that arms a search.
- `abort`  in  1  synchronous return to IDLE.
- `in_stb`  in  1  sample valid.
- `in_mag`  in  DW  unsigned sample magnitude.
- `thr`  in  SW  signed detection threshold; sampled at `start`.
- `acc_rst`  out  1  active-high synchronous clear to the accumulator.
- `acc_ena`  out  1  accumulator enable.
- `acc_a`  out  DW  newest sample.
- `acc_a_d`  out  DW  delayed sample.
- `acc_sum`  in  SW  signed accumulator output.
- `busy`  out  1  high when not in IDLE.
- `det_stb`  out  1  one-cycle detection pulse.
- `det_idx`  out  16  sample index at detection; held until the next `start`.
- `to_stb`  out  1  one-cycle timeout pulse.

## Operation
- **States:** IDLE, CLR, FILL, SEARCH, DETECT.
- **IDLE:**
  - `start` moves the FSM to CLR and latches `thr`.
  - `start` is ignored in any other state.
- **CLR** (exactly 1 cycle):
  - `acc_rst`=1; the delay-line pointer, sample index and plateau counter are cleared.
  - `in_stb` during CLR is dropped.
  - Next state is FILL.
- **FILL:**
  - Each `in_stb` writes `in_mag` into the delay line and drives `acc_a_d`=0, so stale contents are never subtracted.
  - After W accepted samples the FSM moves to SEARCH.
- **SEARCH:** each `in_stb` drives `acc_a_d` from the delay line, reading the oldest entry at the write pointer before it is overwritten.
- **Evaluation:**
  - `acc_sum` is valid in the cycle after an `acc_ena`; the controller compares it then.
  - `acc_sum >= thr` (signed) increments the plateau counter; otherwise the counter resets to 0.
  - When the counter reaches PLAT_LEN, the FSM moves to DETECT.
- **DETECT** (1 cycle): `det_stb`=1 and `det_idx` is set to the index of the completing sample; next state is IDLE.
- **Sample index:** counts accepted samples from 0 at the first FILL sample; 16-bit, wraps.
- **Delay-line pointer:** WIN_LOG bits, natural wrap.
- `acc_ena` = `in_stb` while in FILL or SEARCH. `acc_a` = `in_mag`.
- **`abort`:** in any non-IDLE state, goes to IDLE next cycle with no `det_stb`/`to_stb`. `abort` has priority over `start`.
- **Reset mid-operation:** immediate IDLE; the delay-line contents are don't-care.

## Timing
- **Reset values:** `busy`, `acc_rst`, `acc_ena`, `det_stb` and `to_stb` are 0. `acc_a`, `acc_a_d` and `det_idx` are 0.
- **`start` → `acc_rst`:** asserted in the next cycle.
- **`acc_ena`, `acc_a`, `acc_a_d`:** combinational from `in_stb`, state and the delay-line read.
- **Detection latency:** `det_stb` asserts 2 cycles after the `in_stb` of the completing sample (evaluate cycle, then DETECT).
- **Simultaneous detection and timeout on the same sample:** detection wins and `to_stb` stays 0.
- **`in_stb` gaps:** tolerated in all states; the evaluation of a sample is not lost if the next sample is delayed.

## Configuration
- **`SYNC_TIMEOUT_EN` defined:**
  - SEARCH counts accepted samples; on reaching TIMEOUT without detection it pulses `to_stb` for 1 cycle and goes to IDLE.
- **`SYNC_TIMEOUT_EN` undefined:**
  - SEARCH lasts until detection or `abort`.
  - `to_stb` is tied to 0.

## Structure
- **Shared package:** state encoding typedef and the default width constants (DW=17, SW=23, WIN_LOG=6).
- **Sub-module `sync_delay_line`:** 2^WIN_LOG × DW circular buffer with write enable and same-cycle read-before-write at the write pointer.

## Test plan
- **Fill/detect:** W=64, PLAT_LEN=32, constant `in_mag`=100 every cycle, `thr`=6400 → `acc_a_d`=0 for samples 0..63; `det_stb` once; `det_idx`=95.
- **Plateau break:** as above, but sample 80 = 0 → counter resets; detection at `det_idx`=80+64+31=175 (the window recovers at sample 144).
- **Gapped input:** `in_stb` every third cycle → same `det_idx`=95; `det_stb` 2 cycles after sample 95's strobe.
- **`abort`:** `abort` in SEARCH at sample 70 → IDLE next cycle, `busy`=0, no pulses; a following `start` re-runs the search cleanly.
- **Timeout:** with `SYNC_TIMEOUT_EN`, TIMEOUT=100, `thr`=10000 → `to_stb` after SEARCH sample 99 (sample index 163), then `busy`=0.
- **Async reset:** `rst` low mid-FILL → all outputs 0 immediately; `start` ignored while `busy`.
